// File: rtl/garage_door_pkg.sv
// garage_door_pkg: shared state encoding and sizing helpers for the garage door controller
package garage_door_pkg;
  localparam int STATE_W = 3;
`ifdef GDOOR_AUTOCLOSE_EN
  localparam bit AUTOCLOSE = 1'b1;
`else
  localparam bit AUTOCLOSE = 1'b0;
`endif
  typedef enum logic [STATE_W-1:0] {
    S_OPEN    = 3'd0,
    S_CLOSED  = 3'd1,
    S_OPENING = 3'd2,
    S_CLOSING = 3'd3,
    S_FAULT   = 3'd4
  } state_t;
  function automatic int cnt_w(int travel, int autoclose);
    return $clog2((AUTOCLOSE && autoclose > travel ? autoclose : travel) + 1);
  endfunction
endpackage

// File: rtl/garage_door_ctrl_if.sv
// garage_door_ctrl_if: per-door command, sensor and drive vectors between user logic and the controller
interface garage_door_ctrl_if
  import garage_door_pkg::*;
#(
  parameter int NUM_DOORS = 4
);
  logic [NUM_DOORS-1:0]         open;
  logic [NUM_DOORS-1:0]         close;
  logic [NUM_DOORS-1:0]         door_up;
  logic [NUM_DOORS-1:0]         door_down;
  logic [NUM_DOORS-1:0]         obstacle;
  logic [NUM_DOORS-1:0]         fault_clr;
  logic [NUM_DOORS-1:0]         power_up;
  logic [NUM_DOORS-1:0]         power_down;
  logic [NUM_DOORS-1:0]         fault;
  logic [STATE_W*NUM_DOORS-1:0] state_o;
  modport master (
    output open, close, door_up, door_down, obstacle, fault_clr,
    input  power_up, power_down, fault, state_o
  );
  modport slave (
    input  open, close, door_up, door_down, obstacle, fault_clr,
    output power_up, power_down, fault, state_o
  );
endinterface

// File: rtl/garage_door_channel.sv
// garage_door_channel: one door's FSM, travel/auto-close counter and motor decode (auto-close under GDOOR_AUTOCLOSE_EN)
module garage_door_channel
  import garage_door_pkg::*;
#(
  parameter int TRAVEL_CYCLES    = 200,
  parameter int AUTOCLOSE_CYCLES = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               open,
  input  logic               close,
  input  logic               door_up,
  input  logic               door_down,
  input  logic               obstacle,
  input  logic               fault_clr,
  output logic               power_up,
  output logic               power_down,
  output logic               fault,
  output logic [STATE_W-1:0] state_o
);
  localparam int CW = cnt_w(TRAVEL_CYCLES, AUTOCLOSE_CYCLES);
  state_t        st, nxt;
  logic [CW-1:0] cnt, cnt_nxt, open_cnt;
  logic          t_last, ac_fire, conflict;
  assign conflict = door_up && door_down;
  assign t_last   = cnt == CW'(TRAVEL_CYCLES - 1);
`ifdef GDOOR_AUTOCLOSE_EN
  assign ac_fire  = cnt == CW'(AUTOCLOSE_CYCLES - 1) && !open && !close && !obstacle;
  assign open_cnt = (open || obstacle) ? '0 : cnt + 1'b1;
`else
  assign ac_fire  = 1'b0;
  assign open_cnt = '0;
`endif
  assign state_o = st;
  // next-state selection; a limit-sensor conflict overrides everything outside S_FAULT
  always_comb begin
    nxt = st;
    case (st)
      S_OPEN:    nxt = ((close && !obstacle) || ac_fire) ? S_CLOSING : S_OPEN;
      S_CLOSED:  nxt = open ? S_OPENING : S_CLOSED;
      S_OPENING: nxt = door_up ? S_OPEN : (close && !obstacle) ? S_CLOSING : t_last ? S_FAULT : S_OPENING;
      S_CLOSING: nxt = obstacle ? S_OPENING : door_down ? S_CLOSED : open ? S_OPENING : t_last ? S_FAULT : S_CLOSING;
      S_FAULT:   nxt = (fault_clr && !conflict) ? (door_down ? S_CLOSED : door_up ? S_OPEN : S_OPENING) : S_FAULT;
      default:   nxt = S_FAULT;
    endcase
    if (conflict && st != S_FAULT) nxt = S_FAULT;
  end
  // counter restarts on every state change so a reversal gets a fresh travel budget
  always_comb begin
    cnt_nxt = (nxt != st) ? '0 :
              (st == S_OPENING || st == S_CLOSING) ? cnt + 1'b1 :
              (st == S_OPEN) ? open_cnt : cnt;
  end
  // state, counter and outputs registered together so outputs track the new state with no extra stage
  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= S_OPEN;
      cnt        <= '0;
      power_up   <= 1'b0;
      power_down <= 1'b0;
      fault      <= 1'b0;
    end else begin
      st         <= nxt;
      cnt        <= cnt_nxt;
      power_up   <= nxt == S_OPENING;
      power_down <= nxt == S_CLOSING;
      fault      <= nxt == S_FAULT;
    end
  end
endmodule

// File: rtl/garage_door_ctrl.sv
// garage_door_ctrl: NUM_DOORS independent door channels sliced from a shared interface (auto-close under GDOOR_AUTOCLOSE_EN)
module garage_door_ctrl
  import garage_door_pkg::*;
#(
  parameter int NUM_DOORS        = 4,
  parameter int TRAVEL_CYCLES    = 200,
  parameter int AUTOCLOSE_CYCLES = 1000
) (
  input logic               clock,
  input logic               reset,
  garage_door_ctrl_if.slave bus
);
  for (genvar i = 0; i < NUM_DOORS; i++) begin : g_door
    garage_door_channel #(
      .TRAVEL_CYCLES   (TRAVEL_CYCLES),
      .AUTOCLOSE_CYCLES(AUTOCLOSE_CYCLES)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .open      (bus.open[i]),
      .close     (bus.close[i]),
      .door_up   (bus.door_up[i]),
      .door_down (bus.door_down[i]),
      .obstacle  (bus.obstacle[i]),
      .fault_clr (bus.fault_clr[i]),
      .power_up  (bus.power_up[i]),
      .power_down(bus.power_down[i]),
      .fault     (bus.fault[i]),
      .state_o   (bus.state_o[STATE_W*i +: STATE_W])
    );
  end
endmodule

// File: tb/tb_garage_door_ctrl.sv
// tb_garage_door_ctrl: directed checks of a two-door controller with an 8-cycle travel budget
module tb_garage_door_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  garage_door_ctrl_if #(.NUM_DOORS(2)) bus ();
  garage_door_ctrl #(
    .NUM_DOORS       (2),
    .TRAVEL_CYCLES   (8),
    .AUTOCLOSE_CYCLES(16)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.open = '0; bus.close = '0; bus.door_up = '0;
    bus.door_down = '0; bus.obstacle = '0; bus.fault_clr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pu", 8'(bus.power_up), 8'h0);
    chk("rst_pd", 8'(bus.power_down), 8'h0);
    chk("rst_fault", 8'(bus.fault), 8'h0);
    chk("rst_state", 8'(bus.state_o), 8'h0);
    bus.close[0] = 1'b1; tick(); bus.close[0] = 1'b0;
    chk("close_pd", 8'(bus.power_down), 8'h1);
    chk("close_st0", 8'(bus.state_o[2:0]), 8'd3);
    chk("close_st1", 8'(bus.state_o[5:3]), 8'd0);
    repeat (7) tick();
    chk("to_before", 8'(bus.state_o[2:0]), 8'd3);
    tick();
    chk("to_state", 8'(bus.state_o[2:0]), 8'd4);
    chk("to_pd", 8'(bus.power_down), 8'h0);
    chk("to_fault", 8'(bus.fault), 8'h1);
    bus.fault_clr[0] = 1'b1; bus.door_down[0] = 1'b1; tick(); bus.fault_clr[0] = 1'b0;
    chk("clr_closed", 8'(bus.state_o[2:0]), 8'd1);
    chk("clr_fault", 8'(bus.fault), 8'h0);
    bus.open[0] = 1'b1; tick(); bus.open[0] = 1'b0; bus.door_down[0] = 1'b0;
    chk("open_st", 8'(bus.state_o[2:0]), 8'd2);
    chk("open_pu", 8'(bus.power_up), 8'h1);
    bus.door_up[0] = 1'b1; tick(); bus.door_up[0] = 1'b0;
    chk("up_open", 8'(bus.state_o[2:0]), 8'd0);
    bus.close[0] = 1'b1; tick(); bus.close[0] = 1'b0;
    chk("cl2_st", 8'(bus.state_o[2:0]), 8'd3);
    tick(); tick();
    bus.obstacle[0] = 1'b1; tick(); bus.obstacle[0] = 1'b0;
    chk("rev_st", 8'(bus.state_o[2:0]), 8'd2);
    chk("rev_pu", 8'(bus.power_up), 8'h1);
    chk("rev_pd", 8'(bus.power_down), 8'h0);
    repeat (4) tick();
    chk("rev_run", 8'(bus.state_o[2:0]), 8'd2);
    bus.door_up[0] = 1'b1; tick(); bus.door_up[0] = 1'b0;
    chk("rev_open", 8'(bus.state_o[2:0]), 8'd0);
    bus.close[0] = 1'b1; tick(); bus.close[0] = 1'b0;
    bus.obstacle[0] = 1'b1; bus.door_down[0] = 1'b1; tick();
    bus.obstacle[0] = 1'b0; bus.door_down[0] = 1'b0;
    chk("obs_wins", 8'(bus.state_o[2:0]), 8'd2);
    bus.door_up[0] = 1'b1; bus.door_down[0] = 1'b1; tick();
    chk("conf_st", 8'(bus.state_o[2:0]), 8'd4);
    chk("conf_fault", 8'(bus.fault), 8'h1);
    chk("conf_pu", 8'(bus.power_up), 8'h0);
    bus.fault_clr[0] = 1'b1; tick();
    chk("conf_hold", 8'(bus.state_o[2:0]), 8'd4);
    bus.door_down[0] = 1'b0; tick(); bus.fault_clr[0] = 1'b0;
    chk("clr_open", 8'(bus.state_o[2:0]), 8'd0);
    repeat (9) tick();
    bus.obstacle[0] = 1'b1; tick(); bus.obstacle[0] = 1'b0;
`ifdef GDOOR_AUTOCLOSE_EN
    repeat (15) tick();
    chk("ac_wait", 8'(bus.state_o[2:0]), 8'd0);
    tick();
    chk("ac_close", 8'(bus.state_o[2:0]), 8'd3);
`else
    repeat (100) tick();
    chk("noac_open", 8'(bus.state_o[2:0]), 8'd0);
    chk("noac_pd", 8'(bus.power_down[0]), 8'h0);
`endif
    bus.door_up[0] = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_state", 8'(bus.state_o), 8'h0);
    bus.close[1] = 1'b1; tick(); bus.close[1] = 1'b0;
    chk("d1_closing", 8'(bus.state_o[5:3]), 8'd3);
    bus.open[1] = 1'b1; tick(); bus.open[1] = 1'b0;
    chk("d1_opening", 8'(bus.state_o[5:3]), 8'd2);
    chk("d1_pu", 8'(bus.power_up), 8'h2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstm_pu", 8'(bus.power_up), 8'h0);
    chk("rstm_state", 8'(bus.state_o), 8'h0);
    chk("rstm_fault", 8'(bus.fault), 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/garage_door_ctrl.md
# garage_door_ctrl

Multi-channel garage door controller: the parametrised successor to the single-door open/close state machine. It drives NUM_DOORS independent doors from one clock, each with its own open/close commands and up/down limit sensors. Over the single-door design it adds obstacle reversal, a travel-timeout fault state with explicit clear, sensor-conflict detection, and optional auto-close. It sits between the user command logic and the per-door motor drivers and door models.

## Interface
- NUM_DOORS, 4, number of independent door channels (≥1)
- TRAVEL_CYCLES, 200, max clock cycles a door may be in motion before a fault (≥2)
- AUTOCLOSE_CYCLES, 1000, cycles idle in OPEN before auto-close (≥2; used only with GDOOR_AUTOCLOSE_EN)
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clock
- open  in  NUM_DOORS  per-door open command, level
- close  in  NUM_DOORS  per-door close command, level
- door_up  in  NUM_DOORS  per-door fully-open limit sensor
- door_down  in  NUM_DOORS  per-door fully-closed limit sensor
- obstacle  in  NUM_DOORS  per-door beam-break sensor
- fault_clr  in  NUM_DOORS  per-door fault acknowledge
- power_up  out  NUM_DOORS  motor drive, raise
- power_down  out  NUM_DOORS  motor drive, lower
- fault  out  NUM_DOORS  door in S_FAULT
- state_o  out  3*NUM_DOORS  per-door state code; bits [3i+2:3i] belong to door i

## Operation
- Channels are fully independent. Bit i of every vector belongs to door i.
- States and codes: S_OPEN=0, S_CLOSED=1, S_OPENING=2, S_CLOSING=3, S_FAULT=4.
- Moore outputs decoded from the state register only:
  - power_up=1 only in S_OPENING
  - power_down=1 only in S_CLOSING
  - fault=1 only in S_FAULT
  - power_up and power_down are never both 1.
- Each channel has one counter `cnt` of width $clog2(max(TRAVEL_CYCLES, AUTOCLOSE_CYCLES)+1).
  - cnt clears to 0 on every state change and increments in S_OPENING, S_CLOSING and S_OPEN.
  - cnt never wraps: it is bounded by the transition taken at its terminal count.
- Sensor conflict: door_up & door_down both 1 → S_FAULT from any non-fault state. This is the highest priority.
- Transitions, listed in priority order within each state:
  - S_OPEN: close & !obstacle → S_CLOSING. With auto-close enabled, the auto-close rule applies (see Configuration).
  - S_CLOSED: open → S_OPENING.
  - S_OPENING: door_up → S_OPEN; else close & !obstacle → S_CLOSING; else cnt==TRAVEL_CYCLES-1 → S_FAULT.
  - S_CLOSING: obstacle → S_OPENING (reversal, cnt cleared); else door_down → S_CLOSED; else open → S_OPENING; else cnt==TRAVEL_CYCLES-1 → S_FAULT.
  - S_FAULT: fault_clr & !(door_up & door_down) → S_CLOSED if door_down, S_OPEN if door_up, otherwise S_OPENING. Other inputs are ignored.
- Reset: every channel goes to S_OPEN with cnt=0. All power_up, power_down and fault outputs are 0, and state_o is 0.
- Reset mid-motion drops motor drive on the cycle after the reset edge. No fault is recorded.

## Timing
- A state change is registered on posedge k. Outputs reflect the new state after edge k, with no additional register stage.
- Command-to-motor latency is 1 cycle: open sampled at edge k gives power_up=1 from edge k to k+1.
- Timeout: motion entered at edge k with no limit or command event → S_FAULT at edge k+TRAVEL_CYCLES.
- A reversal restarts the full TRAVEL_CYCLES budget.
- Obstacle reversal takes effect at the first edge where obstacle=1 in S_CLOSING. This holds even if door_down=1 on the same edge: obstacle wins.
- open and close both asserted:
  - S_OPENING continues to S_CLOSING unless door_up.
  - S_CLOSING goes to S_OPENING.
  - S_OPEN with close goes to S_CLOSING; S_CLOSED with open goes to S_OPENING.

## Configuration
- GDOOR_AUTOCLOSE_EN defined:
  - In S_OPEN, cnt clears whenever open or obstacle is 1.
  - cnt==AUTOCLOSE_CYCLES-1 with close=0, open=0, obstacle=0 → S_CLOSING.
  - A door left open therefore closes AUTOCLOSE_CYCLES cycles after its last open/obstacle activity.
- GDOOR_AUTOCLOSE_EN undefined:
  - S_OPEN leaves only on close or sensor conflict.
  - cnt holds at 0 in S_OPEN.
  - AUTOCLOSE_CYCLES is ignored and excluded from the cnt width calculation.

## Structure
- Package garage_door_pkg holds:
  - the 3-bit state type and the S_* constants
  - the state_o field width constant (3)
- Sub-module garage_door_channel: one door's FSM, counter and output decode, with scalar ports.
- garage_door_ctrl is a generate loop of NUM_DOORS garage_door_channel instances plus vector slicing.

## Test plan
- Reset, NUM_DOORS=2 → all outputs 0 and state_o=0 on both doors. Then close[0]=1 for 1 cycle → door 0 power_down=1 after the next edge; door 1 stays S_OPEN.
- TRAVEL_CYCLES=8, door 0 closing, no sensors → S_FAULT exactly 8 edges after entering S_CLOSING, power_down=0, fault[0]=1. fault_clr[0] with door_down=1 → S_CLOSED.
- Closing, obstacle=1 at cycle 3 → S_OPENING next edge with cnt=0 and power_up=1. door_up at cycle 5 after reversal → S_OPEN.
- In S_OPENING, drive door_up=1 and door_down=1 → S_FAULT next edge. fault_clr with both still high → remains S_FAULT.
- GDOOR_AUTOCLOSE_EN, AUTOCLOSE_CYCLES=16, door in S_OPEN, obstacle pulse at cycle 10 → S_CLOSING at cycle 10+16. Without the macro → stays S_OPEN for 100 cycles.
- Reset asserted while door 1 is in S_OPENING → power_up[1]=0 and state S_OPEN after that edge; fault[1]=0.
